alu_4_issue: RTL and testbench

Operation-issue and result-capture stage wrapped around the combinational `alu_4`. It accepts {A, B, CTRL} requests on a valid/ready interface and buffers them in a small FIFO. Each head entry drives `alu_4` for one cycle, and the `alu_4` result is registered, with flags, into a downstream valid/ready output stage. This gives `alu_4` a clocked, back-pressure-aware front end for use in sequenced datapaths.

---
 rtl/alu_4_pkg.sv | 31 +++
 rtl/alu_4_issue_sync_fifo.sv | 56 +++++
 rtl/alu_4_issue.sv | 93 +++++++++
 tb/tb_alu_4_issue.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_4_pkg.sv
// Shared opcode encoding and request layout for alu_4 and its issue stage.
// The request word packs {a, b, ctrl} into 12 bits.
package alu_4_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_XNOR = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_LAST = OP_MUL;

    localparam int DATA_W = 4;
    localparam int RES_W  = 8;
    localparam int REQ_W  = 3 * DATA_W;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] ctrl;
    } alu_req_t;

    function automatic logic is_illegal_op(input logic [3:0] ctrl);
        return ctrl > OP_LAST;
    endfunction

endpackage

// File: rtl/alu_4_issue_sync_fifo.sv
// Synchronous FIFO with an occupancy counter. Full and empty come from the
// count, and the read port shows zero when the FIFO is empty.
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);
    assign rdata = empty ? '0 : mem[rptr];

    // Storage holds data only; contents are meaningless until counted in.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_4_issue.sv
// Issue/capture stage around an external combinational alu_4: requests queue
// in a FIFO, the head drives the ALU, and the result lands in an output register.
module alu_4_issue
    import alu_4_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_a,
    input  logic [3:0]              in_b,
    input  logic [3:0]              in_ctrl,
    output logic [3:0]              alu_a,
    output logic [3:0]              alu_b,
    output logic [3:0]              alu_ctrl,
    input  logic [7:0]              alu_y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_y,
    output logic [3:0]              out_ctrl,
    output logic                    out_zero,
    output logic                    out_err,
    output logic [$clog2(DEPTH):0]  count
);

    alu_req_t          req_p0;
    alu_req_t          head_p0;
    logic [REQ_W-1:0]  head_raw;
    logic              push;
    logic              load;
    logic              empty;
    logic              full;

    logic              vld_p1;
    logic [RES_W-1:0]  y_p1;
    logic [3:0]        ctrl_p1;
    logic              zero_p1;
    logic              err_p1;

    // Stage p0: request queue; head entry drives alu_4 combinationally.
    assign req_p0   = '{a: in_a, b: in_b, ctrl: in_ctrl};
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign load     = !empty && (!vld_p1 || out_ready);

    sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (req_p0),
        .pop   (load),
        .rdata (head_raw),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    assign head_p0  = alu_req_t'(head_raw);
    assign alu_a    = head_p0.a;
    assign alu_b    = head_p0.b;
    assign alu_ctrl = head_p0.ctrl;

    // Stage p1: capture alu_4 result and flags; held stable under back-pressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            y_p1    <= '0;
            ctrl_p1 <= '0;
            zero_p1 <= 1'b0;
            err_p1  <= 1'b0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            y_p1    <= alu_y;
            ctrl_p1 <= head_p0.ctrl;
            zero_p1 <= (alu_y == '0);
            err_p1  <= is_illegal_op(head_p0.ctrl);
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_y     = y_p1;
    assign out_ctrl  = ctrl_p1;
    assign out_zero  = zero_p1;
    assign out_err   = err_p1;

endmodule

// File: tb/tb_alu_4_issue.sv
// Directed bench for alu_4_issue; a behavioural alu_4 closes the loop.
module tb_alu_4_issue;
    import alu_4_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [3:0] in_ctrl;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_ctrl;
    logic [7:0] alu_y;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic [3:0] out_ctrl;
    logic       out_zero;
    logic       out_err;
    logic [2:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_4_issue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ctrl   (in_ctrl),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_y     (alu_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_ctrl  (out_ctrl),
        .out_zero  (out_zero),
        .out_err   (out_err),
        .count     (count)
    );

    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] c);
        logic [7:0] ea;
        logic [7:0] eb;
        ea = {4'b0, a};
        eb = {4'b0, b};
        case (c)
            OP_ADD:  return ea + eb;
            OP_SUB:  return ea - eb;
            OP_AND:  return {4'b0, a & b};
            OP_OR:   return {4'b0, a | b};
            OP_NOT:  return {4'b0, ~a};
            OP_NAND: return {4'b0, ~(a & b)};
            OP_NOR:  return {4'b0, ~(a | b)};
            OP_XOR:  return {4'b0, a ^ b};
            OP_XNOR: return {4'b0, ~(a ^ b)};
            OP_MUL:  return ea * eb;
            default: return 8'd0;
        endcase
    endfunction

    always_comb alu_y = alu_model(alu_a, alu_b, alu_ctrl);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // One request through an idle pipe with out_ready high; starts and ends at negedge.
    task automatic do_one(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [7:0] y,
                          input logic z, input logic e);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_ctrl   = c;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_alu_a"},     32'(alu_a),     32'(a));
        check({tag, "_alu_ctrl"},  32'(alu_ctrl),  32'(c));
        check({tag, "_early_vld"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_vld"},  32'(out_valid), 32'd1);
        check({tag, "_y"},    32'(out_y),     32'(y));
        check({tag, "_ctrl"}, 32'(out_ctrl),  32'(c));
        check({tag, "_zero"}, 32'(out_zero),  32'(z));
        check({tag, "_err"},  32'(out_err),   32'(e));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int accepted;
        int stale;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_vld",   32'(out_valid), 32'd0);
        check("rst_count", 32'(count),     32'd0);
        check("rst_ready", 32'(in_ready),  32'd1);
        check("rst_alu_a", 32'(alu_a),     32'd0);
        check("rst_y",     32'(out_y),     32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_one("add",     4'd3,  4'd5,  OP_ADD, 8'd8,  1'b0, 1'b0);
        do_one("mul",     4'd15, 4'd15, OP_MUL, 8'hE1, 1'b0, 1'b0);
        do_one("xor0",    4'hA,  4'hA,  OP_XOR, 8'd0,  1'b1, 1'b0);
        do_one("illegal", 4'd7,  4'd3,  4'hF,   8'd0,  1'b1, 1'b1);

        // Back-pressure: six offered, five absorbed.
        out_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_a     = 4'(i);
            in_b     = 4'd1;
            in_ctrl  = OP_ADD;
            if (in_ready)
                accepted++;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(accepted), 32'd5);
        check("bp_count",    32'(count),    32'd4);
        check("bp_ready",    32'(in_ready), 32'd0);
        check("bp_hold_y",   32'(out_y),    32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_vld%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_y%0d", k),   32'(out_y),     32'(k + 1));
            @(posedge clk);
            @(negedge clk);
        end
        check("bp_end_vld",   32'(out_valid), 32'd0);
        check("bp_end_count", 32'(count),     32'd0);

        // Reset mid-stream with three queued and one captured.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a     = 4'd9;
            in_b     = 4'd9;
            in_ctrl  = OP_ADD;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("mid_count_pre", 32'(count),     32'd3);
        check("mid_vld_pre",   32'(out_valid), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_vld",   32'(out_valid), 32'd0);
        check("mid_rst_count", 32'(count),     32'd0);
        check("mid_rst_ready", 32'(in_ready),  32'd1);
        check("mid_rst_alu_a", 32'(alu_a),     32'd0);
        check("mid_rst_alu_c", 32'(alu_ctrl),  32'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        stale     = 0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid)
                stale++;
        end
        check("mid_no_stale", 32'(stale), 32'd0);
        do_one("post_or", 4'd5, 4'd3, OP_OR, 8'd7, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish, expected finish by 20000");
        $fatal(1, "timeout");
    end

endmodule
